step_pulse_gen: RTL and testbench
=================================

STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 SHALL have parameter WIDTH_WORK, default 16, width of the period input.
REQ-002 SHALL have parameter PULSE_WIDTH, default 100, step high time in clk cycles (2 us at 50 MHz).
REQ-003 SHALL have parameter DIR_SETUP, default 250, low-time gap in clk cycles between a drv_dir change and the next step rise.
REQ-004 SHALL have parameter MIN_PERIOD, default 200, minimum step period in clk cycles; legal values satisfy MIN_PERIOD >= 2*PULSE_WIDTH.
REQ-005 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1, run request from the tracking stage (drv_enable_SM).
REQ-008 SHALL have port dir_in, input, 1, requested direction.
REQ-009 SHALL have port period, input, WIDTH_WORK, step period in clk cycles (tracking-stage N).
REQ-010 SHALL have port drv_step, output, 1, registered step pulse to the motor driver.
REQ-011 SHALL have port drv_dir, output, 1, registered direction to the motor driver.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port step_count, output, 32, signed position counter.

Function
REQ-014 SHALL implement four states: IDLE, DIR_WAIT, HIGH, LOW.
REQ-015 Period latch: per_r = max(period, MIN_PERIOD); latched only on IDLE exit and at LOW expiry. A period change mid-step affects the next step only.
REQ-016 IDLE: drv_step=0. On a cycle with enable=1 and period!=0, latch per_r. If dir_in==drv_dir, go to HIGH; otherwise set drv_dir<=dir_in and go to DIR_WAIT.
REQ-017 DIR_WAIT: drv_step=0 for exactly DIR_SETUP cycles, then HIGH. If enable=0 in any DIR_WAIT cycle, go to IDLE next cycle with no pulse.
REQ-018 HIGH: drv_step=1 for exactly PULSE_WIDTH cycles, then LOW.
REQ-019 LOW: drv_step=0 for exactly per_r-PULSE_WIDTH cycles. Consecutive step rises in the same direction are therefore exactly per_r cycles apart.
REQ-020 LOW expiry with enable=0 or period==0: go to IDLE.
REQ-021 LOW expiry otherwise: re-latch per_r. If dir_in==drv_dir, go to HIGH; else update drv_dir and go to DIR_WAIT.
REQ-022 enable and dir_in SHALL be ignored during HIGH and LOW. A started step always completes its full period, giving no runt pulse and no short spacing.
REQ-023 Latency: with enable=1 and unchanged direction sampled in IDLE at edge k, drv_step SHALL be 1 after edge k+1.
REQ-024 step_count SHALL change on the same edge that drv_step rises: +1 if drv_dir=1, -1 if drv_dir=0.
REQ-025 step_count SHALL wrap modulo 2^32 (0x7FFFFFFF+1 -> 0x80000000).
REQ-026 drv_dir SHALL change only on entry to DIR_WAIT, never while drv_step=1.
REQ-027 Internal counters SHALL be WIDTH_WORK+1 bits wide, with no overflow for period=2^WIDTH_WORK-1.

Reset
REQ-028 rst=1 SHALL, at the next clk edge and from any state, force IDLE, drv_step=0, drv_dir=0, busy=0, step_count=0, per_r=0 and all counters to 0. rst has priority over every other input.
REQ-029 With rst=0 and enable=1 held after reset, the first step SHALL start with no extra delay beyond REQ-023 and REQ-017.

Verification (bench parameters PULSE_WIDTH=4, DIR_SETUP=6, MIN_PERIOD=10)
REQ-030 Reset, then period=20, dir_in=0, enable=1 from cycle 0 -> drv_step rises at cycle 1 and is high 4 cycles; rises repeat every 20 cycles; step_count reads -1, -2, -3.
REQ-031 Running at dir_in=0, switch dir_in=1 mid-LOW -> the current period completes, then drv_dir=1 for 6 low cycles, then a rise; step_count increments from that rise on.
REQ-032 period=3 -> rises spaced 10 cycles. period=0 in IDLE -> no pulse and busy=0.
REQ-033 enable drops during the 2nd HIGH cycle -> the pulse stays high the full 4 cycles, the 20-cycle period completes, then IDLE with busy=0 and no further rises.
REQ-034 rst asserted during HIGH with step_count=5 -> next cycle drv_step=0, step_count=0, busy=0. With enable still 1 after release, dir_in=0 gives a rise one cycle later.
REQ-035 period changed 20->40 in the 5th cycle of a step -> that step spans 20 cycles and the next spans 40.

Source files
------------

// File: rtl/step_pulse_gen_if.sv
// Bundles the run request from the tracking stage and the motor driver outputs
// of the step pulse generator.
interface step_pulse_gen_if #(
    parameter int WIDTH_WORK = 16
);
    logic                  enable;
    logic                  dir_in;
    logic [WIDTH_WORK-1:0] period;
    logic                  drv_step;
    logic                  drv_dir;
    logic                  busy;
    logic [31:0]           step_count;

    modport master (
        output enable, dir_in, period,
        input  drv_step, drv_dir, busy, step_count
    );

    modport slave (
        input  enable, dir_in, period,
        output drv_step, drv_dir, busy, step_count
    );
endinterface

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper driver: fixed-width step pulses,
// a clamped period, and a direction setup gap before any reversal.
module step_pulse_gen #(
    parameter int WIDTH_WORK  = 16,
    parameter int PULSE_WIDTH = 100,
    parameter int DIR_SETUP   = 250,
    parameter int MIN_PERIOD  = 200
) (
    input logic            clk,
    input logic            rst,
    step_pulse_gen_if.slave bus
);
    localparam int CW = WIDTH_WORK + 1;

    localparam logic [CW-1:0] PW_C    = CW'(PULSE_WIDTH);
    localparam logic [CW-1:0] PW_LAST = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] DS_LAST = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] MIN_P   = CW'(MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        DIR_WAIT,
        HIGH,
        LOW
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] per_r, per_nxt;
    logic          dir_r, dir_nxt;
    logic          step_r;
    logic [31:0]   count_r;

    logic [CW-1:0] period_ext;
    logic [CW-1:0] per_clamped;
    logic [CW-1:0] low_last;
    logic          go;

    assign period_ext  = {1'b0, bus.period};
    assign per_clamped = (period_ext < MIN_P) ? MIN_P : period_ext;
    assign low_last    = per_r - PW_C - CW'(1);
    assign go          = bus.enable && (bus.period != '0);

    // Next-state logic; a new step is only ever launched from IDLE or at LOW expiry
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        per_nxt   = per_r;
        dir_nxt   = dir_r;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (go) begin
                    per_nxt = per_clamped;
                    if (bus.dir_in == dir_r) begin
                        state_nxt = HIGH;
                    end else begin
                        dir_nxt   = bus.dir_in;
                        state_nxt = DIR_WAIT;
                    end
                end
            end
            DIR_WAIT: begin
                if (!bus.enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DS_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end
            end
            HIGH: begin
                if (cnt == PW_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            end
            LOW: begin
                if (cnt == low_last) begin
                    cnt_nxt = '0;
                    if (!go) begin
                        state_nxt = IDLE;
                    end else begin
                        per_nxt = per_clamped;
                        if (bus.dir_in == dir_r) begin
                            state_nxt = HIGH;
                        end else begin
                            dir_nxt   = bus.dir_in;
                            state_nxt = DIR_WAIT;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The step output trails the HIGH state by one clock, so the position
    // counter moves on the exact edge where the registered pulse rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            per_r   <= '0;
            dir_r   <= 1'b0;
            step_r  <= 1'b0;
            count_r <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            per_r  <= per_nxt;
            dir_r  <= dir_nxt;
            step_r <= (state == HIGH);
            if ((state == HIGH) && !step_r) begin
                count_r <= dir_r ? count_r + 32'd1 : count_r - 32'd1;
            end
        end
    end

    assign bus.drv_step   = step_r;
    assign bus.drv_dir    = dir_r;
    assign bus.busy       = (state != IDLE);
    assign bus.step_count = count_r;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: expected step rises are queued as
// stimulus is applied and matched against each observed rise.
module tb_step_pulse_gen;
    localparam int PW = 4;
    localparam int DS = 6;
    localparam int MP = 10;
    localparam int WW = 16;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        logic        dir;
    } rise_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    rise_t sb[$];

    step_pulse_gen_if #(.WIDTH_WORK(WW)) bus ();

    step_pulse_gen #(
        .WIDTH_WORK (WW),
        .PULSE_WIDTH(PW),
        .DIR_SETUP  (DS),
        .MIN_PERIOD (MP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic en, input logic dir, input int per);
        bus.enable = en;
        bus.dir_in = dir;
        bus.period = WW'(per);
    endtask

    task automatic pushRise(input int c, input int cnt, input logic dir);
        rise_t e;
        e.cyc = c;
        e.cnt = 32'(cnt);
        e.dir = dir;
        sb.push_back(e);
    endtask

    task automatic tickTo(input int m);
        while (cyc < m) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Rise monitor: pops the scoreboard on every rise and checks pulse width on every fall
    initial begin
        logic  prev_step;
        logic  cut;
        int    high_len;
        rise_t e;
        prev_step = 1'b0;
        cut       = 1'b0;
        high_len  = 0;
        forever begin
            @(negedge clk);
            if (rst && bus.drv_step) cut = 1'b1;
            if (bus.drv_step && !prev_step) begin
                high_len = 1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rise", 32'(cyc), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rise_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("rise_step_count", bus.step_count, e.cnt);
                    checkOutput("rise_drv_dir", 32'(bus.drv_dir), 32'(e.dir));
                end
            end else if (bus.drv_step) begin
                high_len++;
            end else if (prev_step) begin
                if (!cut) checkOutput("pulse_width", 32'(high_len), 32'(PW));
                cut = 1'b0;
            end
            prev_step = bus.drv_step;
        end
    end

    initial begin
        int c0, d0, e0, r;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 0);

        tickTo(3);
        @(negedge clk);
        checkOutput("reset_drv_step", 32'(bus.drv_step), 32'd0);
        checkOutput("reset_drv_dir", 32'(bus.drv_dir), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_step_count", bus.step_count, 32'd0);

        // Steady run in the negative direction, one cycle of start latency
        c0 = 4;
        tickTo(c0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 20);
        pushRise(c0 + 2, -1, 1'b0);
        pushRise(c0 + 22, -2, 1'b0);
        pushRise(c0 + 42, -3, 1'b0);

        // Reversal requested mid-LOW: period completes, then the setup gap
        tickTo(c0 + 50);
        applyStimulus(1'b1, 1'b1, 20);
        pushRise(c0 + 42 + 20 + DS, -2, 1'b1);
        pushRise(c0 + 42 + 20 + DS + 20, -1, 1'b1);
        tickTo(c0 + 60);
        @(negedge clk);
        checkOutput("dir_hold_in_low", 32'(bus.drv_dir), 32'd0);
        tickTo(c0 + 61);
        @(negedge clk);
        checkOutput("dir_switch", 32'(bus.drv_dir), 32'd1);
        checkOutput("dir_wait_busy", 32'(bus.busy), 32'd1);
        checkOutput("dir_wait_step", 32'(bus.drv_step), 32'd0);

        // Enable dropped during the second high cycle of the rise at c0+88
        tickTo(c0 + 89);
        applyStimulus(1'b0, 1'b1, 20);
        tickTo(c0 + 106);
        @(negedge clk);
        checkOutput("busy_last_low", 32'(bus.busy), 32'd1);
        tickTo(c0 + 107);
        @(negedge clk);
        checkOutput("busy_after_stop", 32'(bus.busy), 32'd0);
        tickTo(c0 + 140);
        @(negedge clk);
        checkOutput("stop_queue_empty", 32'(sb.size()), 32'd0);
        checkOutput("stop_step_count", bus.step_count, 32'hFFFF_FFFF);

        // Short period clamps to MIN_PERIOD; period=0 then parks in IDLE
        d0 = c0 + 141;
        tickTo(d0);
        applyStimulus(1'b1, 1'b1, 3);
        pushRise(d0 + 2, 0, 1'b1);
        pushRise(d0 + 2 + MP, 1, 1'b1);
        pushRise(d0 + 2 + 2 * MP, 2, 1'b1);
        tickTo(d0 + 24);
        applyStimulus(1'b1, 1'b1, 0);
        tickTo(d0 + 50);
        @(negedge clk);
        checkOutput("zero_period_busy", 32'(bus.busy), 32'd0);
        checkOutput("zero_period_step", 32'(bus.drv_step), 32'd0);
        checkOutput("clamp_queue_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a pulse with step_count at 5
        e0 = d0 + 51;
        tickTo(e0);
        applyStimulus(1'b1, 1'b1, 10);
        pushRise(e0 + 2, 3, 1'b1);
        pushRise(e0 + 12, 4, 1'b1);
        pushRise(e0 + 22, 5, 1'b1);
        tickTo(e0 + 23);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 10);
        tickTo(e0 + 24);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 20);
        pushRise(e0 + 26, -1, 1'b0);
        pushRise(e0 + 46, -2, 1'b0);
        @(negedge clk);
        checkOutput("rst_drv_step", 32'(bus.drv_step), 32'd0);
        checkOutput("rst_step_count", bus.step_count, 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_drv_dir", 32'(bus.drv_dir), 32'd0);

        // Period change in the 5th cycle of a step only affects the next step
        r = e0 + 46;
        tickTo(r + 4);
        applyStimulus(1'b1, 1'b0, 40);
        pushRise(r + 20, -3, 1'b0);
        pushRise(r + 60, -4, 1'b0);
        tickTo(r + 61);
        applyStimulus(1'b0, 1'b0, 40);
        tickTo(r + 110);
        @(negedge clk);
        checkOutput("final_queue_empty", 32'(sb.size()), 32'd0);
        checkOutput("final_busy", 32'(bus.busy), 32'd0);
        checkOutput("final_step_count", bus.step_count, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
